// File: rtl/sprite_line_buffer_if.sv
// Sprite write-side bus for sprite_line_buffer.
// Ports (signals):
//   WR_REQ   - sprite pixel write request (master -> slave)
//   WR_X     - sprite pixel X address, XW bits (master -> slave)
//   WR_COL   - sprite pixel colour, 0 = transparent (master -> slave)
//   WR_READY - write can be accepted this edge (slave -> master)
//   WR_BANK  - bank currently owned by the write side (slave -> master)
interface sprite_line_buffer_if #(
  parameter int XW = 8
);
  logic          WR_REQ;
  logic [XW-1:0] WR_X;
  logic [3:0]    WR_COL;
  logic          WR_READY;
  logic          WR_BANK;

  modport master (
    output WR_REQ, WR_X, WR_COL,
    input  WR_READY, WR_BANK
  );

  modport slave (
    input  WR_REQ, WR_X, WR_COL,
    output WR_READY, WR_BANK
  );
endinterface

// File: rtl/sprite_line_buffer.sv
// Double-banked sprite line buffer. The sprite engine merges pixels into the
// write bank (first opaque pixel wins) while the display side reads the other
// bank with clear-after-read; LINE_START swaps the banks.
// Ports:
//   CLK        - master clock, rising edge
//   RESET      - asynchronous active-low reset
//   CEN        - display pixel clock enable (read + clear)
//   LINE_START - one-cycle line boundary pulse: swap banks, restart read counter
//   wr         - sprite write bus (slave modport)
//   COL        - display pixel {transparent, colour[3:0]}
//
// Write FSM:
//   state | meaning
//   IDLE  | ready for a write request
//   MERGE | reading stored pixel at captured X, writing if it was empty
module sprite_line_buffer #(
  parameter int XW = 8
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 CEN,
  input  logic                 LINE_START,
  sprite_line_buffer_if.slave  wr,
  output logic [4:0]           COL
);

  localparam int DEPTH = 1 << XW;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_MERGE = 1'b1;

  logic [0:0]    r_state;
  logic          r_wr_bank;
  logic          r_cap_bank;
  logic [XW-1:0] r_cap_x;
  logic [3:0]    r_cap_col;
  logic [XW-1:0] r_rd_cnt;
  logic [4:0]    r_col;

  // Bank contents are deliberately not reset; clear-after-read empties them.
  logic [3:0]    r_mem [0:1][0:DEPTH-1];

  logic          w_accept;
  logic          w_merge;
  logic [3:0]    w_stored;
  logic          w_do_write;
  logic          w_rd;
  logic          w_rd_bank;
  logic [3:0]    w_rd_pix;

  assign w_accept   = wr.WR_REQ && (r_state == ST_IDLE);
  assign w_merge    = (r_state == ST_MERGE);
  assign w_stored   = r_mem[r_cap_bank][r_cap_x];
  // First-written opaque pixel wins; transparent pixels never write.
  assign w_do_write = w_merge && (w_stored == 4'h0) && (r_cap_col != 4'h0);

  // LINE_START takes priority over a coincident CEN: no read, no clear.
  assign w_rd       = CEN && !LINE_START;
  assign w_rd_bank  = ~r_wr_bank;
  assign w_rd_pix   = r_mem[w_rd_bank][r_rd_cnt];

  assign wr.WR_READY = (r_state == ST_IDLE);
  assign wr.WR_BANK  = r_wr_bank;
  assign COL         = r_col;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state    <= ST_IDLE;
      r_wr_bank  <= 1'b0;
      r_cap_bank <= 1'b0;
      r_cap_x    <= '0;
      r_cap_col  <= 4'h0;
      r_rd_cnt   <= '0;
      r_col      <= 5'h10;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state    <= ST_MERGE;
            r_cap_bank <= r_wr_bank;
            r_cap_x    <= wr.WR_X;
            r_cap_col  <= wr.WR_COL;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (LINE_START) begin
        r_wr_bank <= ~r_wr_bank;
        r_rd_cnt  <= '0;
      end else if (CEN) begin
        r_rd_cnt <= r_rd_cnt + 1'b1;
        r_col    <= {(w_rd_pix == 4'h0), w_rd_pix};
      end
    end
  end

  // The merge targets the captured bank, the display side the other bank.
  // A merge finishing on a LINE_START edge still lands in the captured bank,
  // and that edge performs no display access, so the two never collide.
  // While reset is held the FSM sits in IDLE, so an interrupted merge is lost.
  always_ff @(posedge CLK) begin
    if (w_do_write) begin
      r_mem[r_cap_bank][r_cap_x] <= r_cap_col;
    end
    if (w_rd) begin
      r_mem[w_rd_bank][r_rd_cnt] <= 4'h0;
    end
  end

endmodule

// File: tb/tb_sprite_line_buffer.sv
// Self-checking bench for sprite_line_buffer against a line-level model:
// two arrays of pixels, a bank index and a read position.
module tb_sprite_line_buffer;
  localparam int XW = 8;
  localparam int N  = 1 << XW;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       CEN;
  logic       LINE_START;
  logic [4:0] COL;

  sprite_line_buffer_if #(.XW(XW)) wr();

  sprite_line_buffer #(.XW(XW)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .CEN        (CEN),
    .LINE_START (LINE_START),
    .wr         (wr),
    .COL        (COL)
  );

  always #5 CLK = ~CLK;

  int         m_mem [2][N];
  int         m_bank;
  int         m_cnt;
  logic [4:0] m_col;
  int         errors = 0;
  int         checks = 0;

  function automatic logic [4:0] pix2col(input int p);
    logic [3:0] c;
    c = p[3:0];
    return {(c == 4'h0), c};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic cen_read(input bit chk);
    int p;
    CEN = 1'b1;
    tick();
    CEN = 1'b0;
    p = m_mem[1 - m_bank][m_cnt];
    m_mem[1 - m_bank][m_cnt] = 0;
    m_cnt = (m_cnt + 1) % N;
    m_col = pix2col(p);
    if (chk) begin
      checks++;
      if (COL !== m_col) begin
        errors++;
        $display("FAIL read_col: addr %0d got %h expected %h", (m_cnt + N - 1) % N, COL, m_col);
      end
    end
  endtask

  task automatic read_n(input int n, input bit chk);
    for (int i = 0; i < n; i++) cen_read(chk);
  endtask

  task automatic line_start();
    LINE_START = 1'b1;
    tick();
    LINE_START = 1'b0;
    m_bank = 1 - m_bank;
    m_cnt  = 0;
    checks++;
    if (wr.WR_BANK !== m_bank[0]) begin
      errors++;
      $display("FAIL wr_bank_swap: got %b expected %b", wr.WR_BANK, m_bank[0]);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (wr.WR_READY !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (wr.WR_READY !== 1'b1) begin
      errors++;
      $display("FAIL ready_timeout: got %b expected 1", wr.WR_READY);
    end
  endtask

  task automatic write_px(input int x, input int c);
    wait_ready();
    wr.WR_REQ = 1'b1;
    wr.WR_X   = x[XW-1:0];
    wr.WR_COL = c[3:0];
    tick();
    wr.WR_REQ = 1'b0;
    if (m_mem[m_bank][x] == 0 && c != 0) m_mem[m_bank][x] = c;
    checks++;
    if (wr.WR_READY !== 1'b0) begin
      errors++;
      $display("FAIL ready_drop: got %b expected 0", wr.WR_READY);
    end
    tick();
    checks++;
    if (wr.WR_READY !== 1'b1) begin
      errors++;
      $display("FAIL ready_return: got %b expected 1", wr.WR_READY);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b0; CEN = 1'b0; LINE_START = 1'b0;
    wr.WR_REQ = 1'b0; wr.WR_X = '0; wr.WR_COL = 4'h0;
    m_bank = 0; m_cnt = 0; m_col = 5'h10;
    idle(3);
    checks++;
    if (wr.WR_BANK !== 1'b0 || wr.WR_READY !== 1'b1 || COL !== 5'h10) begin
      errors++;
      $display("FAIL reset_state: got bank=%b ready=%b col=%h expected 0 1 10",
               wr.WR_BANK, wr.WR_READY, COL);
    end
    RESET = 1'b1;
    tick();
    // Bank contents are unknown after power-up: sweep both banks once.
    read_n(N, 1'b0);
    line_start();
    read_n(N, 1'b0);
    line_start();
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < N; i++) m_mem[b][i] = 0;
  endtask

  task automatic test_basic();
    write_px(5, 3);
    line_start();
    read_n(6, 1'b1);
    checks++;
    if (COL !== 5'h03) begin
      errors++;
      $display("FAIL basic_x5: got %h expected 03", COL);
    end
  endtask

  task automatic test_first_wins();
    line_start();
    write_px(9, 7);
    write_px(9, 2);
    line_start();
    read_n(10, 1'b1);
    checks++;
    if (COL !== 5'h07) begin
      errors++;
      $display("FAIL first_wins: got %h expected 07", COL);
    end
  endtask

  task automatic test_transparent();
    write_px(4, 0);
    line_start();
    read_n(5, 1'b1);
    checks++;
    if (COL !== 5'h10) begin
      errors++;
      $display("FAIL transparent_write: got %h expected 10", COL);
    end
  endtask

  task automatic test_wrap();
    int bad = 0;
    line_start();
    write_px(0, 10);
    write_px(255, 12);
    line_start();
    read_n(N, 1'b1);
    checks++;
    if (COL !== 5'h0c) begin
      errors++;
      $display("FAIL last_pixel: got %h expected 0c", COL);
    end
    cen_read(1'b1);
    checks++;
    if (COL !== 5'h10) begin
      errors++;
      $display("FAIL wrap_cleared: got %h expected 10", COL);
    end
    line_start();
    line_start();
    for (int i = 0; i < N; i++) begin
      cen_read(1'b1);
      if (COL !== 5'h10) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL clear_after_read: got %0d non-empty pixels expected 0", bad);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 24; k++) write_px($urandom_range(N - 1), $urandom_range(15));
      line_start();
      for (int i = 0; i < N; i++) begin
        cen_read(1'b1);
        if ($urandom_range(3) == 0) idle($urandom_range(2));
      end
    end
  endtask

  task automatic test_back_to_back();
    int  xs [4];
    int  cs [4];
    bit  exp_rdy;
    wait_ready();
    for (int k = 0; k < 4; k++) begin
      xs[k] = 20 + k;
      cs[k] = 1 + $urandom_range(14);
    end
    for (int k = 0; k < 4; k++) begin
      wr.WR_REQ = 1'b1;
      wr.WR_X   = xs[k][XW-1:0];
      wr.WR_COL = cs[k][3:0];
      exp_rdy   = (k % 2 == 0);
      checks++;
      if (wr.WR_READY !== exp_rdy) begin
        errors++;
        $display("FAIL b2b_ready: cycle %0d got %b expected %b", k, wr.WR_READY, exp_rdy);
      end
      if (exp_rdy && m_mem[m_bank][xs[k]] == 0) m_mem[m_bank][xs[k]] = cs[k];
      tick();
    end
    wr.WR_REQ = 1'b0;
    tick();
    line_start();
    read_n(24, 1'b1);
  endtask

  task automatic test_ls_in_merge();
    int x, c, ob, exp;
    x = $urandom_range(50, 200);
    c = 1 + $urandom_range(14);
    wait_ready();
    wr.WR_REQ = 1'b1;
    wr.WR_X   = x[XW-1:0];
    wr.WR_COL = c[3:0];
    tick();
    wr.WR_REQ  = 1'b0;
    LINE_START = 1'b1;
    ob = m_bank;
    tick();
    LINE_START = 1'b0;
    if (m_mem[ob][x] == 0) m_mem[ob][x] = c;
    exp    = m_mem[ob][x];
    m_bank = 1 - m_bank;
    m_cnt  = 0;
    checks++;
    if (wr.WR_BANK !== m_bank[0]) begin
      errors++;
      $display("FAIL ls_merge_bank: got %b expected %b", wr.WR_BANK, m_bank[0]);
    end
    read_n(x + 1, 1'b1);
    checks++;
    if (COL !== pix2col(exp)) begin
      errors++;
      $display("FAIL ls_merge_pixel: got %h expected %h", COL, pix2col(exp));
    end
  endtask

  task automatic test_ls_with_cen();
    logic [4:0] held;
    int c;
    line_start();
    c = 1 + $urandom_range(14);
    write_px(0, c);
    read_n(7, 1'b1);
    held = COL;
    CEN = 1'b1;
    LINE_START = 1'b1;
    tick();
    CEN = 1'b0;
    LINE_START = 1'b0;
    m_bank = 1 - m_bank;
    m_cnt  = 0;
    checks++;
    if (COL !== held) begin
      errors++;
      $display("FAIL ls_cen_hold: got %h expected %h", COL, held);
    end
    cen_read(1'b1);
    checks++;
    if (COL !== pix2col(c)) begin
      errors++;
      $display("FAIL ls_cen_addr0: got %h expected %h", COL, pix2col(c));
    end
  endtask

  task automatic test_reset_merge();
    int x, prior;
    x = $urandom_range(30, 60);
    wait_ready();
    prior = m_mem[m_bank][x];
    wr.WR_REQ = 1'b1;
    wr.WR_X   = x[XW-1:0];
    wr.WR_COL = 4'h9;
    tick();
    wr.WR_REQ = 1'b0;
    RESET = 1'b0;
    #1;
    checks++;
    if (wr.WR_READY !== 1'b1 || COL !== 5'h10) begin
      errors++;
      $display("FAIL async_reset: got ready=%b col=%h expected 1 10", wr.WR_READY, COL);
    end
    tick();
    RESET = 1'b1;
    m_bank = 0; m_cnt = 0; m_col = 5'h10;
    tick();
    checks++;
    if (wr.WR_BANK !== 1'b0) begin
      errors++;
      $display("FAIL reset_bank: got %b expected 0", wr.WR_BANK);
    end
    // Dropped merge targeted bank 0 only if the write bank was 0; check both.
    line_start();
    read_n(N, 1'b1);
    line_start();
    read_n(x + 1, 1'b1);
    if (prior == 0) begin
      checks++;
      if (COL !== 5'h10) begin
        errors++;
        $display("FAIL reset_drop: got %h expected 10", COL);
      end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_basic();
    test_first_wins();
    test_transparent();
    test_wrap();
    test_random();
    test_back_to_back();
    test_ls_in_merge();
    test_ls_with_cen();
    test_reset_merge();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
